// File: rtl/mult_sequencer.sv
// Shift-and-add multiply sequencer: issues one decoder selector code per cycle,
// an add per set multiplier bit (LSB first) followed by a shift, then display and done.
module mult_sequencer #(
    parameter int unsigned      N        = 4,
    parameter int unsigned      SEL_W    = 5,
    parameter logic [SEL_W-1:0] SEL_IDLE = SEL_W'(4)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             multiplier,
    output logic [SEL_W-1:0]         selector,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N+1)-1:0]   step
);
    localparam int unsigned STEP_W = $clog2(N+1);

    localparam logic [SEL_W-1:0] M_CLEARLD = SEL_W'(0);
    localparam logic [SEL_W-1:0] M_ADD     = SEL_W'(2);
    localparam logic [SEL_W-1:0] M_SHTR    = SEL_W'(3);
    localparam logic [SEL_W-1:0] M_DISP    = SEL_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_DISP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N-1:0]        r_m;
    logic [N-1:0]        w_m_shr;
    logic [SEL_W-1:0]    r_sel;
    logic                r_busy;
    logic                r_done;
    logic [STEP_W-1:0]   r_step;

    // Bit 0 of the shifted shadow is the next multiplier bit; avoids indexing r_m[1] when N=1.
    assign w_m_shr = r_m >> 1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLEAR;
            S_CLEAR: w_next = r_m[0] ? S_ADD : S_SHIFT;
            S_ADD:   w_next = S_SHIFT;
            S_SHIFT: begin
                if (r_step == STEP_W'(1)) w_next = S_DISP;
                else                      w_next = w_m_shr[0] ? S_ADD : S_SHIFT;
            end
            S_DISP:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_step  <= '0;
            r_m     <= '0;
        end else begin
            r_state <= w_next;
            // busy stays low in DONE; start is only sampled from IDLE regardless.
            r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done  <= (w_next == S_DONE);
            case (w_next)
                S_CLEAR: r_sel <= M_CLEARLD;
                S_ADD:   r_sel <= M_ADD;
                S_SHIFT: r_sel <= M_SHTR;
                S_DISP:  r_sel <= M_DISP;
                default: r_sel <= SEL_IDLE;
            endcase
            if (r_state == S_IDLE && start) begin
                r_m    <= multiplier;
                r_step <= STEP_W'(N);
            end else if (r_state == S_SHIFT) begin
                r_m    <= w_m_shr;
                r_step <= r_step - 1'b1;
            end
        end
    end

    assign selector = r_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign step     = r_step;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes expected per-cycle outputs,
// negedge monitors pop and compare whenever a DUT is busy or pulsing done.
module tb_mult_sequencer;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, start1;
    logic [3:0] mult4;
    logic [0:0] mult1;
    logic [4:0] sel4, sel1;
    logic       busy4, busy1, done4, done1;
    logic [2:0] step4;
    logic [0:0] step1;

    mult_sequencer #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .multiplier(mult4),
        .selector(sel4), .busy(busy4), .done(done4), .step(step4)
    );

    mult_sequencer #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .multiplier(mult1),
        .selector(sel1), .busy(busy1), .done(done1), .step(step1)
    );

    typedef struct packed {
        logic [15:0] cyc;
        logic [4:0]  sel;
        logic        busy;
        logic        done;
        logic [2:0]  step;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cmp_entry(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual cyc=%0d sel=%0d busy=%0b done=%0b step=%0d required cyc=%0d sel=%0d busy=%0b done=%0b step=%0d",
                     name, act.cyc, act.sel, act.busy, act.done, act.step,
                     req.cyc, req.sel, req.busy, req.done, req.step);
        end
    endtask

    function automatic exp_t mk(input int c, input int s, input bit b, input bit d, input int st);
        exp_t e;
        e.cyc  = 16'(c);
        e.sel  = 5'(s);
        e.busy = b;
        e.done = d;
        e.step = 3'(st);
        return e;
    endfunction

    // Reference: CLEAR, then per bit (LSB first) an optional ADD and a SHIFT, then DISP, DONE.
    task automatic push_op(input int which, input logic [3:0] mv, input int n, input int acc, input int keep);
        exp_t seq[$];
        int   c = acc + 1;
        seq.push_back(mk(c++, 0, 1'b1, 1'b0, n));
        for (int i = 0; i < n; i++) begin
            if (mv[i]) seq.push_back(mk(c++, 2, 1'b1, 1'b0, n - i));
            seq.push_back(mk(c++, 3, 1'b1, 1'b0, n - i));
        end
        seq.push_back(mk(c++, 4, 1'b1, 1'b0, 0));
        seq.push_back(mk(c++, 4, 1'b0, 1'b1, 0));
        for (int i = 0; i < seq.size() && i < keep; i++) begin
            if (which == 4) q4.push_back(seq[i]);
            else            q1.push_back(seq[i]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (busy4 === 1'b1 || done4 === 1'b1)) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut4_unexpected actual cyc=%0d sel=%0d busy=%0b done=%0b required none", cyc, sel4, busy4, done4);
            end else begin
                cmp_entry("dut4_seq", exp_t'{16'(cyc), sel4, busy4, done4, step4}, q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && (busy1 === 1'b1 || done1 === 1'b1)) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected actual cyc=%0d sel=%0d busy=%0b done=%0b required none", cyc, sel1, busy1, done1);
            end else begin
                cmp_entry("dut1_seq", exp_t'{16'(cyc), sel1, busy1, done1, {2'b00, step1}}, q1.pop_front());
            end
        end
    end

    function automatic bit is_idle(input int which);
        if (which == 4) return q4.size() == 0 && busy4 !== 1'b1 && done4 !== 1'b1;
        else            return q1.size() == 0 && busy1 !== 1'b1 && done1 !== 1'b1;
    endfunction

    task automatic wait_idle(input int which, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < bound && !is_idle(which));
        if (!is_idle(which)) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_dut%0d actual=timeout required=idle within %0d cycles", which, bound);
            q4.delete();
            q1.delete();
        end
    endtask

    task automatic run_op(input int which, input logic [3:0] mv);
        @(posedge clk);
        #1;
        if (which == 4) begin start4 = 1'b1; mult4 = mv; end
        else            begin start1 = 1'b1; mult1 = mv[0]; end
        push_op(which, mv, (which == 4) ? 4 : 1, cyc, 99);
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start1 = 1'b0;
        mult4  = ~mv;
        mult1  = ~mv[0];
        wait_idle(which, 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int next_acc;
        int accepts;
        int n;

        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; mult4 = '0; mult1 = '0;
        @(posedge clk);
        @(negedge clk);
        check("reset_sel4",  32'(sel4),  32'd4);
        check("reset_busy4", 32'(busy4), 32'd0);
        check("reset_done4", 32'(done4), 32'd0);
        check("reset_step4", 32'(step4), 32'd0);
        check("reset_sel1",  32'(sel1),  32'd4);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // multiplier 1011: 0,2,3,2,3,3,2,3,4 then DONE
        run_op(4, 4'b1011);

        // multiplier 0000, with a start pulse landing in DONE that must be ignored
        @(posedge clk);
        #1;
        start4 = 1'b1; mult4 = 4'b0000;
        push_op(4, 4'b0000, 4, cyc, 99);
        @(posedge clk);
        #1 start4 = 1'b0; mult4 = 4'b1111;
        n = 0;
        do begin @(negedge clk); n++; end while (n < 40 && done4 !== 1'b1);
        check("done_seen_0000", 32'(done4), 32'd1);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("start_in_done_ignored", 32'(busy4), 32'd0);
        end
        wait_idle(4, 40);

        run_op(4, 4'b1111);

        // start held high while the operand toggles every cycle
        @(posedge clk);
        #1 start4 = 1'b1;
        next_acc = cyc;
        accepts  = 0;
        while (accepts < 2) begin
            mult4 = cyc[0] ? 4'b1001 : 4'b0110;
            if (cyc == next_acc) begin
                push_op(4, mult4, 4, cyc, 99);
                next_acc = cyc + 7 + $countones(mult4) + 1;
                accepts++;
            end
            @(posedge clk);
            #1;
        end
        start4 = 1'b0;
        wait_idle(4, 40);

        // reset during the second SHIFT of the 1011 sequence
        @(posedge clk);
        #1;
        start4 = 1'b1; mult4 = 4'b1011;
        acc = cyc;
        push_op(4, 4'b1011, 4, acc, 5);
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_sel",   32'(sel4),  32'd4);
        check("abort_busy",  32'(busy4), 32'd0);
        check("abort_done",  32'(done4), 32'd0);
        check("abort_step",  32'(step4), 32'd0);
        check("abort_queue", 32'(q4.size()), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done4), 32'd0);
        end

        run_op(4, 4'b0101);

        // N=1 instance
        run_op(1, 4'b0001);
        run_op(1, 4'b0000);

        repeat (3) @(negedge clk);
        check("final_q4_empty", 32'(q4.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
